alu_exec_unit: RTL and testbench

Execution unit that consumes the 3-bit ALU control code produced by the MIPS ALU decoder and executes the operation on two register operands. ADD, SUB and SLT complete in one cycle. MUL (MIPS32 "mul", low word only) runs as an iterative shift-add multiply across WIDTH cycles. A start/busy/done handshake lets the multi-cycle datapath stall on MUL.

---
 rtl/mips_pkg.sv | 16 +
 rtl/alu_exec_unit_if.sv | 26 ++
 rtl/seq_multiplier.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 106 ++++++++++
 tb/tb_alu_exec_unit.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS ALU definitions.
// Holds the 3-bit ALU control codes produced by the ALU decoder and consumed by
// alu_exec_unit, plus a helper that classifies codes by latency.
package mips_pkg;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b101;

  // True for codes that take the iterative multiply path.
  function automatic logic is_multi_cycle(logic [2:0] code);
    return code == ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for alu_exec_unit.
// master: issues start/alu_control/src_a/src_b, observes busy/done/result/zero/illegal.
// slave : the execution unit side.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output start, alu_control, src_a, src_b,
    input  busy, done, result, zero, illegal
  );

  modport slave (
    input  start, alu_control, src_a, src_b,
    output busy, done, result, zero, illegal
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier producing the low WIDTH bits of a*b.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : latch a_i/b_i, clear accumulator and counter
//   step_i        : perform one shift-add iteration
//   acc_o         : accumulator value including the current step's add
//   finished_o    : this step is the last one (count reaches WIDTH on this edge)
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] acc_o,
  output logic             finished_o
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] acc_step;

  assign acc_step   = mplier_q[0] ? acc_q + mcand_q : acc_q;
  assign acc_o      = acc_step;
  assign finished_o = step_i && (count_q == CntW'(WIDTH - 1));

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    count_d  = count_q;
    if (load_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      count_d  = '0;
    end else if (step_i) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      count_q  <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: ADD/SUB/SLT in one cycle, MUL (low word) over WIDTH cycles.
// Ports:
//   clk, rst : clock, async active-low reset
//   bus      : alu_exec_unit_if.slave (start/alu_control/src_a/src_b in,
//              busy/done/result/zero/illegal out)
module alu_exec_unit
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic            clk,
  input logic            rst,
  alu_exec_unit_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             mul_load, mul_step, mul_finished;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] single_res;
  logic             single_ill;

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i     (clk),
    .rst_ni    (rst),
    .load_i    (mul_load),
    .step_i    (mul_step),
    .a_i       (bus.src_a),
    .b_i       (bus.src_b),
    .acc_o     (mul_acc),
    .finished_o(mul_finished)
  );

  always_comb begin
    single_res = '0;
    single_ill = 1'b0;
    case (bus.alu_control)
      ALU_ADD: single_res = bus.src_a + bus.src_b;
      ALU_SUB: single_res = bus.src_a - bus.src_b;
      ALU_SLT: single_res = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      default: single_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          if (is_multi_cycle(bus.alu_control)) begin
            mul_load = 1'b1;
            state_d  = StMul;
          end else begin
            state_d   = StDone;
            result_d  = single_res;
            zero_d    = (single_res == '0);
            illegal_d = single_ill;
          end
        end
      end
      StMul: begin
        // start is ignored here; no queueing while busy
        mul_step = 1'b1;
        if (mul_finished) begin
          state_d   = StDone;
          result_d  = mul_acc;
          zero_d    = (mul_acc == '0);
          illegal_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.busy    = (state_q == StMul);
  assign bus.done    = (state_q == StDone);
  assign bus.result  = result_q;
  assign bus.zero    = zero_q;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit with a result scoreboard.
module tb_alu_exec_unit;
  import mips_pkg::*;

  localparam int unsigned W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(
    .WIDTH(W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   tests_run = 0;
  int   failed    = 0;

  function automatic exp_t model(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    e.ill = 1'b0;
    case (op)
      ALU_ADD: e.res = a + b;
      ALU_SUB: e.res = a - b;
      ALU_SLT: e.res = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      ALU_MUL: e.res = a * b;
      default: begin
        e.res = '0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  // Presents a request, optionally records its expected outcome, and returns
  // 1ns after the sampling edge with start deasserted.
  task automatic drive_start(input logic [2:0] op, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit push);
    bus.start       = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
    if (push) exp_q.push_back(model(op, a, b));
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    #2;
    tests_run++;
    if (bus.busy !== 1'b0) begin
      failed++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
    end
    tests_run++;
    if (bus.done !== 1'b0) begin
      failed++; $display("FAIL reset_done: got %b, required 0", bus.done);
    end
    tests_run++;
    if (bus.result !== '0 || bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin
      failed++;
      $display("FAIL reset_outputs: got result=%h zero=%b illegal=%b, required 0/0/0",
               bus.result, bus.zero, bus.illegal);
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_add();
    drive_start(ALU_ADD, W'(5), W'(7), 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== W'(12)) begin
      failed++;
      $display("FAIL add_5_7: got done=%b busy=%b result=%h, required 1/0/0000000c",
               bus.done, bus.busy, bus.result);
    end
  endtask

  task automatic test_back_to_back();
    drive_start(ALU_SUB, W'(5), W'(5), 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b1 || bus.result !== '0 || bus.zero !== 1'b1) begin
      failed++;
      $display("FAIL sub_5_5: got done=%b result=%h zero=%b, required 1/0/1",
               bus.done, bus.result, bus.zero);
    end
    drive_start(ALU_SLT, {W{1'b1}}, W'(1), 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b1 || bus.result !== W'(1) || bus.zero !== 1'b0) begin
      failed++;
      $display("FAIL slt_m1_1: got done=%b result=%h zero=%b, required 1/1/0",
               bus.done, bus.result, bus.zero);
    end
  endtask

  task automatic test_mul();
    int busy_cnt = 0;
    int done_cnt = 0;
    int done_idx = -1;
    drive_start(ALU_MUL, {W{1'b1}}, W'(3), 1'b1);
    for (int i = 0; i < int'(W) + 4; i++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (i == 5) begin
        // ADD 1+1 while busy: must be dropped
        bus.start = 1'b1; bus.alu_control = ALU_ADD; bus.src_a = W'(1); bus.src_b = W'(1);
      end
      if (i == 6) bus.start = 1'b0;
    end
    tests_run++;
    if (busy_cnt != int'(W)) begin
      failed++; $display("FAIL mul_busy_cycles: got %0d, required %0d", busy_cnt, W);
    end
    tests_run++;
    if (done_cnt != 1) begin
      failed++; $display("FAIL mul_done_pulses: got %0d, required 1", done_cnt);
    end
    tests_run++;
    if (done_idx != int'(W)) begin
      failed++; $display("FAIL mul_latency: got %0d, required %0d", done_idx, W);
    end
    tests_run++;
    if (bus.result !== 32'hFFFF_FFFD) begin
      failed++; $display("FAIL mul_result_hold: got %h, required fffffffd", bus.result);
    end
  endtask

  task automatic test_mul_zero();
    int idx = -1;
    drive_start(ALU_MUL, 32'h1234_5678, W'(0), 1'b1);
    for (int i = 0; i < int'(W) + 4 && idx < 0; i++) begin
      @(negedge clk);
      if (bus.done) idx = i;
    end
    tests_run++;
    if (idx != int'(W) || bus.result !== '0 || bus.zero !== 1'b1) begin
      failed++;
      $display("FAIL mul_by_zero: got idx=%0d result=%h zero=%b, required %0d/0/1",
               idx, bus.result, bus.zero, W);
    end
    // New MUL accepted in the done cycle
    drive_start(ALU_MUL, W'(7), W'(9), 1'b1);
    idx = -1;
    for (int i = 0; i < int'(W) + 4 && idx < 0; i++) begin
      @(negedge clk);
      if (bus.done) idx = i;
    end
    tests_run++;
    if (idx != int'(W) || bus.result !== W'(63) || bus.zero !== 1'b0) begin
      failed++;
      $display("FAIL mul_in_done_cycle: got idx=%0d result=%h zero=%b, required %0d/3f/0",
               idx, bus.result, bus.zero, W);
    end
  endtask

  task automatic test_illegal();
    drive_start(3'b111, W'(3), W'(4), 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b1 || bus.illegal !== 1'b1 || bus.zero !== 1'b1 || bus.result !== '0)
    begin
      failed++;
      $display("FAIL illegal_111: got done=%b illegal=%b zero=%b result=%h, required 1/1/1/0",
               bus.done, bus.illegal, bus.zero, bus.result);
    end
    drive_start(ALU_ADD, W'(1), W'(2), 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.illegal !== 1'b0 || bus.result !== W'(3)) begin
      failed++;
      $display("FAIL illegal_clear: got illegal=%b result=%h, required 0/3",
               bus.illegal, bus.result);
    end
  endtask

  task automatic test_reset_mid_mul();
    int done_cnt = 0;
    drive_start(ALU_MUL, W'(9), W'(9), 1'b1);
    repeat (10) @(negedge clk);
    #3 rst = 1'b0;
    exp_q.delete();
    #1;
    tests_run++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 ||
        bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin
      failed++;
      $display("FAIL reset_mid_mul: got busy=%b done=%b result=%h zero=%b illegal=%b, %s",
               bus.busy, bus.done, bus.result, bus.zero, bus.illegal, "required all 0");
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < int'(W) + 4; i++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    tests_run++;
    if (done_cnt != 0) begin
      failed++; $display("FAIL reset_no_done: got %0d pulses, required 0", done_cnt);
    end
    drive_start(ALU_ADD, W'(2), W'(3), 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.done !== 1'b1 || bus.result !== W'(5)) begin
      failed++;
      $display("FAIL add_after_reset: got done=%b result=%h, required 1/5", bus.done, bus.result);
    end
  endtask

  initial begin
    exp_t e;
    bus.start       = 1'b0;
    bus.alu_control = 3'b000;
    bus.src_a       = '0;
    bus.src_b       = '0;

    // Scoreboard: every done pulse pops and checks one expected completion
    fork
      forever begin
        @(negedge clk);
        if (bus.done === 1'b1) begin
          tests_run++;
          if (exp_q.size() == 0) begin
            failed++;
            $display("FAIL sb_unexpected_done: got done with result=%h, required no done",
                     bus.result);
          end else begin
            e = exp_q.pop_front();
            if ({bus.result, bus.zero, bus.illegal} !== e) begin
              failed++;
              $display("FAIL sb_result: got %h/%b/%b, required %h/%b/%b",
                       bus.result, bus.zero, bus.illegal, e.res, e.zero, e.ill);
            end
          end
          tests_run++;
          if (bus.busy !== 1'b0) begin
            failed++; $display("FAIL done_with_busy: got busy=%b, required 0", bus.busy);
          end
        end
      end
    join_none

    test_reset();
    test_add();
    test_back_to_back();
    test_mul();
    test_mul_zero();
    test_illegal();
    test_reset_mid_mul();

    repeat (3) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      failed++; $display("FAIL sb_drain: got %0d pending, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
